// File: rtl/pump_relay_arbiter.sv
// Pump relay arbiter: grants the relay to manual dose or auto fill by mode,
// with estop abort, max-on watchdog fault and min-off cooldown.
module pump_relay_arbiter #(
  parameter int CNT_W          = 26,
  parameter int MAX_ON_CYCLES  = 40000000,
  parameter int MIN_OFF_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic        estop,
  input  logic        manual_req,
  input  logic        auto_req,
  input  logic        fault_clr,
  output logic        relay,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        fault,
  output logic [15:0] run_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN_MAN,
    S_RUN_AUTO,
    S_COOL,
    S_FAULT
  } state_e;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MAX_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF_CYCLES - 1);

  state_e      state_q, state_d;
  logic [CNT_W-1:0] on_cnt_q, on_cnt_d;
  logic [CNT_W-1:0] off_cnt_q, off_cnt_d;
  logic        man_armed_q, man_armed_d;
  logic        auto_armed_q, auto_armed_d;
  logic [15:0] run_cnt_q, run_cnt_d;
  logic        relay_q, relay_d;
  logic [1:0]  owner_q, owner_d;
  logic        busy_q, busy_d;
  logic        fault_q, fault_d;
  logic        man_abort, auto_abort, done;
  logic        run_now, run_next;

  always_comb begin
    state_d    = state_q;
    man_abort  = 1'b0;
    auto_abort = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!estop) begin
          if (mode == 2'b00 && manual_req && man_armed_q)
            state_d = S_RUN_MAN;
          else if (mode == 2'b01 && auto_req && auto_armed_q)
            state_d = S_RUN_AUTO;
        end
      end
      S_RUN_MAN: begin
        if (estop || mode != 2'b00) begin
          state_d   = S_COOL;
          man_abort = 1'b1;
        end else if (on_cnt_q == ON_LAST) begin
          state_d = S_FAULT;
        end else if (!manual_req) begin
          state_d = S_COOL;
          done    = 1'b1;
        end
      end
      S_RUN_AUTO: begin
        if (estop || mode != 2'b01) begin
          state_d    = S_COOL;
          auto_abort = 1'b1;
        end else if (on_cnt_q == ON_LAST) begin
          state_d = S_FAULT;
        end else if (!auto_req) begin
          state_d = S_COOL;
          done    = 1'b1;
        end
      end
      S_COOL: begin
        if (off_cnt_q == OFF_LAST) state_d = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clr && !estop) state_d = S_COOL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A released request always rearms, even in the abort cycle itself.
  always_comb begin
    man_armed_d  = !manual_req ? 1'b1 :
                   (man_abort ? 1'b0 : man_armed_q);
    auto_armed_d = !auto_req ? 1'b1 :
                   (auto_abort ? 1'b0 : auto_armed_q);
    run_cnt_d    = run_cnt_q;
    if (done && run_cnt_q != 16'hFFFF)
      run_cnt_d = run_cnt_q + 16'd1;
  end

  always_comb begin
    run_now   = (state_q == S_RUN_MAN) || (state_q == S_RUN_AUTO);
    run_next  = (state_d == S_RUN_MAN) || (state_d == S_RUN_AUTO);
    on_cnt_d  = (run_now && run_next) ? on_cnt_q + CNT_W'(1) : '0;
    off_cnt_d = (state_q == S_COOL && state_d == S_COOL) ?
                off_cnt_q + CNT_W'(1) : '0;
  end

  always_comb begin
    relay_d = 1'b0;
    owner_d = 2'b00;
    busy_d  = 1'b0;
    fault_d = 1'b0;
    unique case (state_d)
      S_RUN_MAN: begin
        relay_d = 1'b1;
        owner_d = 2'b01;
        busy_d  = 1'b1;
      end
      S_RUN_AUTO: begin
        relay_d = 1'b1;
        owner_d = 2'b10;
        busy_d  = 1'b1;
      end
      S_COOL:  busy_d = 1'b1;
      S_FAULT: begin
        owner_d = 2'b11;
        fault_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      on_cnt_q     <= '0;
      off_cnt_q    <= '0;
      man_armed_q  <= 1'b1;
      auto_armed_q <= 1'b1;
      run_cnt_q    <= '0;
      relay_q      <= 1'b0;
      owner_q      <= 2'b00;
      busy_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      on_cnt_q     <= on_cnt_d;
      off_cnt_q    <= off_cnt_d;
      man_armed_q  <= man_armed_d;
      auto_armed_q <= auto_armed_d;
      run_cnt_q    <= run_cnt_d;
      relay_q      <= relay_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
    end
  end

  assign relay     = relay_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign run_count = run_cnt_q;

endmodule
